// File: rtl/mipi_pll_reset_ctrl.sv
// rtl/mipi_pll_reset_ctrl.sv - MIPI PLL reset sequencer and lock qualifier
//
// Drives the MIPI PLL reset pulse and waits for lock. Each lock attempt has
// a timeout, and the number of retries is bounded. Lock must be stable for
// LOCK_STABLE cycles before the downstream reset is released. If lock is
// lost while running, the full sequence starts again.
//
// Ports:
//   refclk     - 50 MHz reference clock
//   rst        - asynchronous active-high reset
//   pll_locked - raw PLL lock, asynchronous to refclk
//   restart    - single-cycle request to restart the full sequence
//   pll_rst    - PLL reset, active-high
//   sys_rst    - downstream MIPI-domain reset, active-high
//   ready      - clocks qualified, sys_rst released
//   fail       - retry budget exhausted
//   retry_cnt  - failed lock attempts in the current sequence
//   state      - current FSM state (debug)

module mipi_pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE     = 1;
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  logic             sync1_q, locked_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // Two-flop synchronizer for the asynchronous lock signal.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // State register, together with the registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign retry_inc = retry_q + 4'd1;

  // Next-state logic. Every exit clears the counter. Each terminal compare
  // fires before the counter could pass its limit, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          // If lock arrives on the timeout cycle, lock takes priority.
          if (locked_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!locked_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = 4'd0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state. They are registered so that
  // they change on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mipi_pll_reset_ctrl.sv
// tb/tb_mipi_pll_reset_ctrl.sv - scoreboard bench for mipi_pll_reset_ctrl

module tb_mipi_pll_reset_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int cyc;
  int applied;
  int miscompares;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic       pr;
    logic       sr;
    logic       rd;
    logic       fl;
    logic [3:0] rc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mipi_pll_reset_ctrl #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .LOCK_STABLE   (8),
    .MAX_RETRY     (2),
    .CNT_W         (16)
  ) dut (
    .refclk    (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // cyc counts posedges; after the Nth edge, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expectation for the negedge that follows edge c, keeping the queue sorted.
  task automatic expect_at(input int c, input string n, input int st, input bit pr,
                           input bit sr, input bit rd, input bit fl, input int rc);
    exp_t e;
    int   i;
    e.cyc = c; e.name = n; e.st = 3'(st); e.pr = pr; e.sr = sr;
    e.rd = rd; e.fl = fl; e.rc = 4'(rc);
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  // Advance until just after edge c. Inputs driven here are sampled at edge c+1.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every expectation that is due on this negedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      applied++;
      if (mon_e.cyc < cyc) begin
        miscompares++;
        $display("FAIL %s: stale expectation for cyc %0d seen at cyc %0d", mon_e.name, mon_e.cyc, cyc);
      end else if ({state, pll_rst, sys_rst, ready, fail, retry_cnt} !==
                   {mon_e.st, mon_e.pr, mon_e.sr, mon_e.rd, mon_e.fl, mon_e.rc}) begin
        miscompares++;
        $display("FAIL %s @cyc %0d: got st=%0d pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d, want st=%0d pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d",
                 mon_e.name, cyc, state, pll_rst, sys_rst, ready, fail, retry_cnt,
                 mon_e.st, mon_e.pr, mon_e.sr, mon_e.rd, mon_e.fl, mon_e.rc);
      end
    end
  end

  initial begin
    int r, l, d, l2, x, g, y, z, l3, rr;
    cyc = 0; applied = 0; miscompares = 0;
    rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;

    // Reset state, then release. pll_rst is held for 4 edges.
    goto(3);
    r = cyc;
    expect_at(r, "reset_state", 0, 1, 1, 0, 0, 0);
    rst = 1'b0;
    expect_at(r + 3, "pll_rst_last_cycle", 0, 1, 1, 0, 0, 0);
    expect_at(r + 4, "pll_rst_release",    1, 0, 1, 0, 0, 0);

    // Nominal lock: 2 sync + 1 + 8 = 11 edges to RUN.
    l = r + 10;
    expect_at(l + 2,  "nom_still_wait", 1, 0, 1, 0, 0, 0);
    expect_at(l + 3,  "nom_stable",     2, 0, 1, 0, 0, 0);
    expect_at(l + 10, "nom_pre_run",    2, 0, 1, 0, 0, 0);
    expect_at(l + 11, "nom_run",        3, 0, 0, 1, 0, 0);
    goto(l);
    pll_locked = 1'b1;

    // Lock loss in RUN: two sync stages plus the transition edge.
    d  = l + 14;
    l2 = d + 8;
    expect_at(d + 2,   "loss_still_run",  3, 0, 0, 1, 0, 0);
    expect_at(d + 3,   "loss_reset",      0, 1, 1, 0, 0, 0);
    expect_at(d + 6,   "loss_pulse_end",  0, 1, 1, 0, 0, 0);
    expect_at(d + 7,   "loss_wait",       1, 0, 1, 0, 0, 0);
    expect_at(l2 + 10, "relock_stable",   2, 0, 1, 0, 0, 0);
    expect_at(l2 + 11, "relock_run",      3, 0, 0, 1, 0, 0);
    goto(d);
    pll_locked = 1'b0;
    goto(l2);
    pll_locked = 1'b1;

    // Restart from RUN, then a lock glitch during STABLE.
    x = l2 + 14;
    g = x + 6;
    expect_at(x + 1,  "restart_run",      0, 1, 1, 0, 0, 0);
    expect_at(x + 5,  "glitch_wait",      1, 0, 1, 0, 0, 0);
    expect_at(g + 7,  "glitch_stable",    2, 0, 1, 0, 0, 0);
    expect_at(g + 8,  "glitch_back_wait", 1, 0, 1, 0, 0, 0);
    expect_at(g + 9,  "glitch_wait2",     1, 0, 1, 0, 0, 0);
    expect_at(g + 10, "glitch_restable",  2, 0, 1, 0, 0, 0);
    expect_at(g + 17, "glitch_full_cnt",  2, 0, 1, 0, 0, 0);
    expect_at(g + 18, "glitch_run",       3, 0, 0, 1, 0, 0);
    goto(x);
    restart = 1'b1; pll_locked = 1'b0;
    goto(x + 1);
    restart = 1'b0;
    goto(g);
    pll_locked = 1'b1;
    goto(g + 5);
    pll_locked = 1'b0;
    goto(g + 7);
    pll_locked = 1'b1;

    // Timeout and fail: drop lock in RUN, never relock.
    y = g + 20;
    expect_at(y + 2,  "to_still_run",    3, 0, 0, 1, 0, 0);
    expect_at(y + 3,  "to_reset1",       0, 1, 1, 0, 0, 0);
    expect_at(y + 26, "to_wait1_last",   1, 0, 1, 0, 0, 0);
    expect_at(y + 27, "to_retry1",       0, 1, 1, 0, 0, 1);
    expect_at(y + 30, "to_pulse2_end",   0, 1, 1, 0, 0, 1);
    expect_at(y + 31, "to_wait2",        1, 0, 1, 0, 0, 1);
    expect_at(y + 50, "to_wait2_last",   1, 0, 1, 0, 0, 1);
    expect_at(y + 51, "to_fail",         4, 1, 1, 0, 1, 2);
    expect_at(y + 59, "fail_held",       4, 1, 1, 0, 1, 2);
    goto(y);
    pll_locked = 1'b0;

    // Restart out of FAIL, then restart on the timeout cycle, then nominal.
    z  = y + 60;
    l3 = z + 30;
    expect_at(z + 1,   "restart_fail",     0, 1, 1, 0, 0, 0);
    expect_at(z + 24,  "rs_timeout_cycle", 1, 0, 1, 0, 0, 0);
    expect_at(z + 25,  "rs_beats_timeout", 0, 1, 1, 0, 0, 0);
    expect_at(z + 29,  "rs_wait",          1, 0, 1, 0, 0, 0);
    expect_at(l3 + 10, "rs_stable",        2, 0, 1, 0, 0, 0);
    expect_at(l3 + 11, "rs_run",           3, 0, 0, 1, 0, 0);
    goto(z);
    restart = 1'b1;
    goto(z + 1);
    restart = 1'b0;
    goto(z + 24);
    restart = 1'b1;
    goto(z + 25);
    restart = 1'b0;
    goto(l3);
    pll_locked = 1'b1;

    // Asynchronous reset mid-RUN, seen before the next refclk edge.
    rr = l3 + 13;
    goto(rr);
    expect_at(rr, "async_rst", 0, 1, 1, 0, 0, 0);
    rst = 1'b1;

    goto(rr + 2);
    for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never checked", sb.size());
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
